// File: rtl/ps2_key_encoder_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard encoder.
//   PS2_EXT / PS2_BRK / PS2_PAUSE : prefix bytes (E0, F0, E1)
//   PS2_ACK and the other response bytes : keyboard replies, never key codes
//   PS2_KEY_W                     : width of the {toggle,pressed,ext,code} word
//   frame_state_t                 : serial frame FSM states
package ps2_pkg;

    localparam int          PS2_KEY_W  = 11;

    localparam logic [7:0]  PS2_EXT    = 8'hE0;
    localparam logic [7:0]  PS2_BRK    = 8'hF0;
    localparam logic [7:0]  PS2_PAUSE  = 8'hE1;
    localparam logic [7:0]  PS2_ACK    = 8'hFA;
    localparam logic [7:0]  PS2_RESEND = 8'hFE;
    localparam logic [7:0]  PS2_ECHO   = 8'hEE;
    localparam logic [7:0]  PS2_BAT_OK = 8'hAA;
    localparam logic [7:0]  PS2_ERR_LO = 8'h00;
    localparam logic [7:0]  PS2_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Bytes the keyboard sends as command replies / self-test status.
    function automatic logic is_kbd_response(input logic [7:0] b);
        return (b == PS2_ACK)    || (b == PS2_RESEND) || (b == PS2_ECHO) ||
               (b == PS2_BAT_OK) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// ps2_key_encoder_if: bundle between the PS/2 pins and the key consumer.
//   ps2_clk, ps2_dat : raw PS/2 lines (asynchronous)
//   ps2_key          : {toggle, pressed, extended, code[7:0]}
//   frame_err        : one-cycle error pulse
// Modports: master drives the lines and observes the result (pins/bridge side),
//           slave is the encoder.
import ps2_pkg::*;

interface ps2_key_encoder_if;
    logic                 ps2_clk;
    logic                 ps2_dat;
    logic [PS2_KEY_W-1:0] ps2_key;
    logic                 frame_err;

    modport master (
        output ps2_clk,
        output ps2_dat,
        input  ps2_key,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output ps2_key,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_encoder_line_filter.sv
// ps2_line_filter: 2-FF synchroniser followed by a stability filter.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset (filtered output resets to 1)
//   raw     : asynchronous input line
//   filt    : filtered line; follows raw after it has been stable FILT_LEN cycles
// Parameter FILT_LEN (1..255).
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic filt
);

    logic [1:0] sync_reg;
    logic [7:0] cnt_reg;
    logic       filt_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
            cnt_reg  <= 8'd0;
            filt_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            // The counter measures how long the synchronised line has
            // disagreed with the filtered value; any agreement restarts it.
            if (sync_reg[1] == filt_reg) begin
                cnt_reg <= 8'd0;
            end else if (cnt_reg == 8'(FILT_LEN - 1)) begin
                filt_reg <= sync_reg[1];
                cnt_reg  <= 8'd0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard line decoder producing the toggle-event word.
//   clk_sys : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : ps2_key_encoder_if.slave (ps2_clk/ps2_dat in, ps2_key/frame_err out)
// Parameters: FILT_LEN (line filter length), TIMEOUT_CYC (max gap between
// clock falling edges inside a frame).
// Optional macro PS2_TYPEMATIC_FILTER_EN: suppress repeated makes of the
// last pressed key (keyboard auto-repeat).
import ps2_pkg::*;

module ps2_key_encoder #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 6000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    ps2_key_encoder_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    // ---------------- input conditioning ----------------
    logic [1:0] raw_lines;
    logic [1:0] filt_lines;   // [0] = clock, [1] = data

    assign raw_lines = {bus.ps2_dat, bus.ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .raw     (raw_lines[gi]),
                .filt    (filt_lines[gi])
            );
        end
    endgenerate

    logic clk_prev_reg;
    logic fall_edge;
    logic dat_bit;

    assign fall_edge = clk_prev_reg & ~filt_lines[0];
    assign dat_bit   = filt_lines[1];

    // ---------------- frame FSM ----------------
    frame_state_t    state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            par_ok_reg, par_ok_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            byte_valid_reg, byte_valid_next;
    logic            frame_err_reg, frame_err_next;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_reg   <= 1'b1;
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            par_ok_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            clk_prev_reg   <= filt_lines[0];
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            par_ok_reg     <= par_ok_next;
            to_cnt_reg     <= to_cnt_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        par_ok_next     = par_ok_reg;
        to_cnt_next     = '0;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fall_edge) begin
                    if (!dat_bit) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_edge) begin
                    shift_next = {dat_bit, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    par_ok_next = ^{shift_reg, dat_bit};
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    if (dat_bit && par_ok_reg) begin
                        byte_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Inter-edge watchdog. An edge wins over an expiring count because the
        // edge branch above already advanced the frame and the count stays 0.
        if (state_reg != IDLE && !fall_edge) begin
            if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                frame_err_next = 1'b1;
                state_next     = IDLE;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    // ---------------- prefix FSM ----------------
    logic                 ext_reg;
    logic                 brk_reg;
    logic [2:0]           skip_reg;
    logic [PS2_KEY_W-1:0] key_reg;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_reg;
    logic       last_valid_reg;
    logic       make_match;

    assign make_match = last_valid_reg && (last_make_reg == {ext_reg, shift_reg});
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_reg        <= 1'b0;
            brk_reg        <= 1'b0;
            skip_reg       <= 3'd0;
            key_reg        <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_make_reg  <= 9'd0;
            last_valid_reg <= 1'b0;
`endif
        end else if (frame_err_reg) begin
            // A broken frame may have carried a prefix; forget pending state.
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
            skip_reg <= 3'd0;
        end else if (byte_valid_reg) begin
            if (skip_reg != 3'd0) begin
                skip_reg <= skip_reg - 3'd1;
            end else if (shift_reg == PS2_PAUSE) begin
                // E1 plus seven more bytes form the Pause sequence.
                skip_reg <= 3'd7;
            end else if (shift_reg == PS2_EXT) begin
                ext_reg <= 1'b1;
            end else if (shift_reg == PS2_BRK) begin
                brk_reg <= 1'b1;
            end else if (is_kbd_response(shift_reg) && !ext_reg && !brk_reg) begin
                // keyboard reply, not a key
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!brk_reg) begin
                    if (!make_match) begin
                        key_reg        <= {~key_reg[10], 1'b1, ext_reg, shift_reg};
                        last_make_reg  <= {ext_reg, shift_reg};
                        last_valid_reg <= 1'b1;
                    end
                end else begin
                    key_reg <= {~key_reg[10], 1'b0, ext_reg, shift_reg};
                    if (make_match) begin
                        last_valid_reg <= 1'b0;
                    end
                end
`else
                key_reg <= {~key_reg[10], ~brk_reg, ext_reg, shift_reg};
`endif
            end
        end
    end

    assign bus.ps2_key   = key_reg;
    assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed, table-driven bench for ps2_key_encoder.
// Drives PS/2 frames onto the interface and checks ps2_key / frame_err.
`timescale 1ns/1ps
import ps2_pkg::*;

module tb_ps2_key_encoder;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 400;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    ps2_key_encoder_if bus();

    ps2_key_encoder #(.FILT_LEN(FILT), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int err_cycles = 0;   // cycles with frame_err high
    int toggles = 0;      // observed flips of ps2_key[10]
    logic prev_t = 1'b0;

    always @(posedge clk_sys) begin
        if (bus.frame_err === 1'b1) err_cycles++;
        if (bus.ps2_key[10] !== prev_t) toggles++;
        prev_t = bus.ps2_key[10];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        logic [10:0] exp_key;
        int          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bit(input logic v);
        bus.ps2_dat = v;
        cycles(10);
        bus.ps2_clk = 1'b0;
        cycles(20);
        bus.ps2_clk = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0] w;
        w = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(w[i]);
        bus.ps2_dat = 1'b1;
        cycles(20);
    endtask

    initial begin
        int   e0;
        int   t0;
        logic [10:0] k0;

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;

        vecs.push_back('{8'h1C, 1'b0, 11'h61C, 0});
        vecs.push_back('{8'hE0, 1'b0, 11'h61C, 0});
        vecs.push_back('{8'hF0, 1'b0, 11'h61C, 0});
        vecs.push_back('{8'h75, 1'b0, 11'h175, 0});
        vecs.push_back('{8'h1C, 1'b1, 11'h175, 1});
        vecs.push_back('{8'h1B, 1'b0, 11'h61B, 0});
        vecs.push_back('{8'hFA, 1'b0, 11'h61B, 0});
        vecs.push_back('{8'hE0, 1'b0, 11'h61B, 0});
        vecs.push_back('{8'hFA, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'hE1, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'h14, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'h77, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'hE1, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'hF0, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'h14, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'hF0, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'h77, 1'b0, 11'h3FA, 0});
        vecs.push_back('{8'h29, 1'b0, 11'h629, 0});
        vecs.push_back('{8'hF0, 1'b0, 11'h629, 0});
        vecs.push_back('{8'h29, 1'b0, 11'h029, 0});
        vecs.push_back('{8'hE0, 1'b0, 11'h029, 0});
        vecs.push_back('{8'hF0, 1'b1, 11'h029, 1});
        vecs.push_back('{8'h1B, 1'b0, 11'h61B, 0});

        // reset state
        cycles(5);
        @(negedge clk_sys);
        check("reset_key", 32'(bus.ps2_key), 32'h0);
        check("reset_err", 32'(bus.frame_err), 32'h0);
        reset_n = 1'b1;
        cycles(10);

        // table-driven frames
        foreach (vecs[i]) begin
            e0 = err_cycles;
            send_frame(vecs[i].code, vecs[i].bad_par);
            @(negedge clk_sys);
            $display("vec %0d code=%h bad_par=%0d key=%h err_cycles=%0d",
                     i, vecs[i].code, vecs[i].bad_par, bus.ps2_key, err_cycles - e0);
            check($sformatf("vec%0d_key", i), 32'(bus.ps2_key), 32'(vecs[i].exp_key));
            check($sformatf("vec%0d_err", i), 32'(err_cycles - e0), 32'(vecs[i].exp_err));
        end

        // timeout after 4 data bits
        e0 = err_cycles;
        k0 = bus.ps2_key;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        cycles(TIMEOUT + 60);
        @(negedge clk_sys);
        $display("timeout: key=%h err_cycles=%0d", bus.ps2_key, err_cycles - e0);
        check("timeout_err", 32'(err_cycles - e0), 32'd1);
        check("timeout_key", 32'(bus.ps2_key), 32'(k0));
        send_frame(8'h23, 1'b0);
        @(negedge clk_sys);
        $display("after timeout: code=23 key=%h", bus.ps2_key);
        check("post_timeout_key", 32'(bus.ps2_key), 32'h223);

        // reset in the middle of the data bits
        e0 = err_cycles;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset_n = 1'b0;
        cycles(2);
        @(negedge clk_sys);
        check("midreset_key", 32'(bus.ps2_key), 32'h0);
        check("midreset_err", 32'(bus.frame_err), 32'h0);
        cycles(3);
        reset_n = 1'b1;
        cycles(TIMEOUT + 20);
        @(negedge clk_sys);
        check("midreset_no_err", 32'(err_cycles - e0), 32'd0);
        send_frame(8'h1C, 1'b0);
        @(negedge clk_sys);
        $display("after reset: code=1C key=%h", bus.ps2_key);
        check("post_reset_key", 32'(bus.ps2_key), 32'h61C);

        // auto-repeat of one make code, then its break
        t0 = toggles;
        for (int i = 0; i < 3; i++) send_frame(8'h1D, 1'b0);
        @(negedge clk_sys);
        $display("repeat make 1D x3: key=%h toggles=%0d", bus.ps2_key, toggles - t0);
        check("repeat_key", 32'(bus.ps2_key), 32'h21D);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("repeat_toggles", 32'(toggles - t0), 32'd1);
`else
        check("repeat_toggles", 32'(toggles - t0), 32'd3);
`endif
        t0 = toggles;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        @(negedge clk_sys);
        $display("break F0 1D: key=%h toggles=%0d", bus.ps2_key, toggles - t0);
        check("break_key", 32'(bus.ps2_key), 32'h41D);
        check("break_toggles", 32'(toggles - t0), 32'd1);
        send_frame(8'h1D, 1'b0);
        @(negedge clk_sys);
        $display("make 1D after break: key=%h", bus.ps2_key);
        check("remake_key", 32'(bus.ps2_key), 32'h21D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
